// File: rtl/spu_pkg.sv
// Shared SPU-lite definitions: register geometry, register-file state encoding
// and a small address range helper.
package spu_pkg;

  localparam int unsigned REG_WIDTH   = 128;
  localparam int unsigned REG_COUNT   = 128;
  localparam int unsigned REG_LOGSIZE = $clog2(REG_COUNT);

  typedef logic [REG_LOGSIZE-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]   reg_data_t;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // Addresses are widened to 32 bits so non-power-of-2 sizes compare cleanly.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned size);
    return (addr < size);
  endfunction

endpackage

// File: rtl/rf_write_arbiter.sv
// Resolves which enabled write port targets a given address (highest index wins)
// and flags when more than one enabled port targets it.
module rf_write_arbiter
  import spu_pkg::*;
#(
  parameter int unsigned WIDTH   = REG_WIDTH,
  parameter int unsigned LOGSIZE = REG_LOGSIZE,
  parameter int unsigned NUM_WR  = 2
) (
  input  logic [NUM_WR-1:0]         i_wr_en,
  input  logic [NUM_WR*LOGSIZE-1:0] i_wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]   i_wr_data,
  input  logic [LOGSIZE-1:0]        i_match_addr,
  output logic                      o_hit_c,
  output logic [WIDTH-1:0]          o_data_c,
  output logic                      o_multi_c
);

  // Later ports overwrite earlier matches, giving highest-index priority.
  always_comb begin
    o_hit_c   = 1'b0;
    o_data_c  = '0;
    o_multi_c = 1'b0;
    for (int j = 0; j < int'(NUM_WR); j++) begin
      if (i_wr_en[j] && (i_wr_addr[j*LOGSIZE +: LOGSIZE] == i_match_addr)) begin
        o_multi_c = o_multi_c | o_hit_c;
        o_hit_c   = 1'b1;
        o_data_c  = i_wr_data[j*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/spu_regfile_mp.sv
// Multi-port SPU register file: clocked writes, registered write-first reads,
// and a zeroing sweep after every reset before accesses are honoured.
module spu_regfile_mp
  import spu_pkg::*;
#(
  parameter int unsigned WIDTH   = REG_WIDTH,
  parameter int unsigned SIZE    = REG_COUNT,
  parameter int unsigned NUM_WR  = 2,
  parameter int unsigned NUM_RD  = 6,
  localparam int unsigned LOGSIZE = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR*LOGSIZE-1:0] wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]   wr_data,
  input  logic [NUM_RD*LOGSIZE-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]   rd_data,
  output logic                      init_busy,
  output logic                      wr_conflict
);

  rf_state_e                 r_state;
  rf_state_e                 w_state_nxt;
  logic [LOGSIZE-1:0]        r_ptr;
  logic [LOGSIZE-1:0]        w_ptr_nxt;
  logic                      r_init_busy;
  logic                      r_wr_conflict;
  logic [NUM_RD*WIDTH-1:0]   r_rd_data;
  logic [WIDTH-1:0]          r_mem [SIZE];

  logic [NUM_RD-1:0]         w_byp_hit;
  logic [NUM_RD-1:0]         w_rd_multi;
  logic [NUM_RD-1:0]         w_rd_ok;
  logic [WIDTH-1:0]          w_byp_data [NUM_RD];
  logic [NUM_WR-1:0]         w_wr_hit;
  logic [NUM_WR-1:0]         w_wr_multi;
  logic [NUM_WR-1:0]         w_wr_ok;
  logic [WIDTH-1:0]          w_wr_data [NUM_WR];
  logic                      w_conflict;

  // Bypass resolution for every read port.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    rf_write_arbiter #(
      .WIDTH   (WIDTH),
      .LOGSIZE (LOGSIZE),
      .NUM_WR  (NUM_WR)
    ) u_byp_arb (
      .i_wr_en      (wr_en),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .i_match_addr (rd_addr[gi*LOGSIZE +: LOGSIZE]),
      .o_hit_c      (w_byp_hit[gi]),
      .o_data_c     (w_byp_data[gi]),
      .o_multi_c    (w_rd_multi[gi])
    );
    assign w_rd_ok[gi] = addr_in_range(32'(rd_addr[gi*LOGSIZE +: LOGSIZE]), SIZE);
  end

  // Each write address gets the winning data, so same-address writers agree.
  for (genvar gj = 0; gj < NUM_WR; gj++) begin : g_wr
    rf_write_arbiter #(
      .WIDTH   (WIDTH),
      .LOGSIZE (LOGSIZE),
      .NUM_WR  (NUM_WR)
    ) u_wr_arb (
      .i_wr_en      (wr_en),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .i_match_addr (wr_addr[gj*LOGSIZE +: LOGSIZE]),
      .o_hit_c      (w_wr_hit[gj]),
      .o_data_c     (w_wr_data[gj]),
      .o_multi_c    (w_wr_multi[gj])
    );
    assign w_wr_ok[gj] = addr_in_range(32'(wr_addr[gj*LOGSIZE +: LOGSIZE]), SIZE);
  end

  // A multi-hit on any probed address implies two enabled writes share it.
  assign w_conflict = (|w_wr_multi) | (|w_rd_multi);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      RF_INIT: begin
        w_ptr_nxt = r_ptr + LOGSIZE'(1);
        if (r_ptr == LOGSIZE'(SIZE - 1)) begin
          w_state_nxt = RF_READY;
          w_ptr_nxt   = '0;
        end
      end
      RF_READY: begin
        w_state_nxt = RF_READY;
      end
      default: begin
        w_state_nxt = RF_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RF_INIT;
      r_ptr         <= '0;
      r_init_busy   <= 1'b1;
      r_wr_conflict <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_init_busy   <= (w_state_nxt == RF_INIT);
      r_wr_conflict <= (r_state == RF_READY) && w_conflict;
    end
  end

  // Storage is not reset; the sweep clears it instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == RF_INIT) begin
        r_mem[r_ptr] <= '0;
      end else begin
        for (int j = 0; j < int'(NUM_WR); j++) begin
          if (w_wr_hit[j] && w_wr_ok[j]) begin
            r_mem[wr_addr[j*LOGSIZE +: LOGSIZE]] <= w_wr_data[j];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (r_state == RF_INIT)) begin
      r_rd_data <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_RD); i++) begin
        if (!w_rd_ok[i]) begin
          r_rd_data[i*WIDTH +: WIDTH] <= '0;
        end else if (w_byp_hit[i]) begin
          r_rd_data[i*WIDTH +: WIDTH] <= w_byp_data[i];
        end else begin
          r_rd_data[i*WIDTH +: WIDTH] <= r_mem[rd_addr[i*LOGSIZE +: LOGSIZE]];
        end
      end
    end
  end

  assign rd_data     = r_rd_data;
  assign init_busy   = r_init_busy;
  assign wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_spu_regfile_mp.sv
// Scoreboard bench for spu_regfile_mp: directed stimulus pushes expectations,
// a negedge monitor pops and compares them in cycle order.
module tb_spu_regfile_mp;
  import spu_pkg::*;

  localparam int unsigned W  = 128;
  localparam int unsigned L  = 7;
  localparam int unsigned NW = 2;
  localparam int unsigned NR = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, reset_s;
  logic [NW-1:0]     wr_en, wr_en_s;
  logic [NW*L-1:0]   wr_addr, wr_addr_s;
  logic [NW*W-1:0]   wr_data, wr_data_s;
  logic [NR*L-1:0]   rd_addr, rd_addr_s;
  logic [NR*W-1:0]   rd_data, rd_data_s;
  logic              init_busy, init_busy_s;
  logic              wr_conflict, wr_conflict_s;

  spu_regfile_mp dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .init_busy(init_busy), .wr_conflict(wr_conflict)
  );

  spu_regfile_mp #(.SIZE(100)) dut_s (
    .clk(clk), .reset(reset_s), .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .rd_addr(rd_addr_s), .rd_data(rd_data_s), .init_busy(init_busy_s), .wr_conflict(wr_conflict_s)
  );

  typedef struct {
    int unsigned cyc;
    int          kind;
    int          port;
    logic [W-1:0] val;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] actual(input int kind, input int port);
    case (kind)
      0: return rd_data[port*W +: W];
      1: return W'(init_busy);
      2: return W'(wr_conflict);
      3: return rd_data_s[port*W +: W];
      4: return W'(init_busy_s);
      5: return W'(wr_conflict_s);
      default: return '0;
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      0: return "rd_data";
      1: return "init_busy";
      2: return "wr_conflict";
      3: return "rd_data_s100";
      4: return "init_busy_s100";
      5: return "wr_conflict_s100";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: compare every expectation due by this cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [W-1:0] a;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      a = actual(e.kind, e.port);
      n_tests++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s[%0d] late check: at cycle %0d, required at cycle %0d", kname(e.kind), e.port, cyc, e.cyc);
      end else if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s[%0d] cycle %0d: got %h, expected %h", kname(e.kind), e.port, cyc, a, e.val);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expn(input int kind, input int port, input logic [W-1:0] v);
    exp_t e;
    e.cyc  = cyc + 1;
    e.kind = kind;
    e.port = port;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic exp_rd_all(input logic [W-1:0] v);
    for (int p = 0; p < int'(NR); p++) expn(0, p, v);
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*L +: L] = L'(a);
  endtask

  task automatic set_wr(input int p, input logic en, input int a, input logic [W-1:0] d);
    wr_en[p]          = en;
    wr_addr[p*L +: L] = L'(a);
    wr_data[p*W +: W] = d;
  endtask

  task automatic set_rd_s(input int p, input int a);
    rd_addr_s[p*L +: L] = L'(a);
  endtask

  task automatic set_wr_s(input int p, input logic en, input int a, input logic [W-1:0] d);
    wr_en_s[p]          = en;
    wr_addr_s[p*L +: L] = L'(a);
    wr_data_s[p*W +: W] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks pending", q.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] pat_a;
    logic [W-1:0] pat_5;
    pat_a = {8{16'hAAAA}};
    pat_5 = {8{16'h5555}};

    reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    reset_s = 1'b1; wr_en_s = '0; wr_addr_s = '0; wr_data_s = '0; rd_addr_s = '0;
    for (int p = 0; p < int'(NR); p++) set_rd(p, 5);

    // Reset state and the 128-edge init sweep
    expn(1, 0, W'(1)); expn(2, 0, '0); exp_rd_all('0); tick();
    expn(1, 0, W'(1)); tick();
    reset = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      expn(1, 0, (k < 128) ? W'(1) : W'(0));
      expn(0, 0, '0);
      expn(0, 5, '0);
      tick();
    end
    exp_rd_all('0); expn(1, 0, '0); expn(2, 0, '0); tick();

    // Basic dual-port write, then read on all ports
    set_wr(0, 1'b1, 3, pat_a); set_wr(1, 1'b1, 7, pat_5);
    expn(2, 0, '0); tick();
    wr_en = '0;
    for (int p = 0; p < int'(NR); p++) begin
      set_rd(p, (p % 2 == 1) ? 7 : 3);
      expn(0, p, (p % 2 == 1) ? pat_5 : pat_a);
    end
    tick();
    for (int p = 0; p < int'(NR); p++) begin
      set_rd(p, (p % 2 == 1) ? 3 : 7);
      expn(0, p, (p % 2 == 1) ? pat_a : pat_5);
    end
    tick();

    // Write-first bypass
    set_wr(0, 1'b1, 10, W'(32'hDEAD)); tick();
    wr_en = '0; set_rd(0, 10); expn(0, 0, W'(32'hDEAD)); tick();
    set_wr(1, 1'b1, 10, W'(32'h1234)); set_wr(0, 1'b1, 11, W'(32'h5678));
    set_rd(1, 10); set_rd(2, 11);
    expn(0, 0, W'(32'h1234)); expn(0, 1, W'(32'h1234)); expn(0, 2, W'(32'h5678)); expn(2, 0, '0);
    tick();
    wr_en = '0;
    expn(0, 0, W'(32'h1234)); expn(0, 2, W'(32'h5678)); tick();
    set_wr(0, 1'b1, 10, W'(32'h9999)); set_wr(1, 1'b1, 12, W'(32'h4242));
    set_rd(1, 12);
    expn(0, 0, W'(32'h9999)); expn(0, 1, W'(32'h4242)); tick();
    wr_en = '0;
    expn(0, 0, W'(32'h9999)); expn(0, 1, W'(32'h4242)); tick();

    // Same-address conflict: port 1 wins, one-cycle flag
    set_wr(0, 1'b1, 20, W'(1)); set_wr(1, 1'b1, 20, W'(2));
    set_rd(0, 20); set_rd(1, 20);
    expn(0, 0, W'(2)); expn(0, 1, W'(2)); expn(2, 0, W'(1)); tick();
    wr_en = '0;
    expn(0, 0, W'(2)); expn(2, 0, '0); tick();

    // Reset mid-operation and mid-sweep
    set_wr(1, 1'b1, 9, W'(32'hFF)); tick();
    wr_en = '0; set_rd(0, 9); set_rd(1, 2);
    expn(0, 0, W'(32'hFF)); tick();
    reset = 1'b1;
    expn(1, 0, W'(1)); expn(0, 0, '0); expn(2, 0, '0); tick();
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      expn(1, 0, W'(1)); tick();
    end
    reset = 1'b1;
    expn(1, 0, W'(1)); tick();
    reset = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      if (k % 2 == 1) begin
        set_wr(0, 1'b1, 2, W'(32'hBEEF)); set_wr(1, 1'b1, 2, W'(32'hBEE2));
      end else begin
        set_wr(0, 1'b1, 2, W'(32'hBEEF)); set_wr(1, 1'b1, 9, W'(32'hAB));
      end
      expn(1, 0, (k < 128) ? W'(1) : W'(0));
      expn(2, 0, '0);
      expn(0, 0, '0);
      tick();
    end
    wr_en = '0;
    expn(0, 0, '0); expn(0, 1, '0); expn(1, 0, '0); tick();

    // SIZE=100 instance: sweep length and out-of-range addresses
    for (int p = 0; p < int'(NR); p++) set_rd_s(p, 0);
    expn(4, 0, W'(1)); expn(3, 0, '0); tick();
    reset_s = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      expn(4, 0, (k < 100) ? W'(1) : W'(0));
      expn(3, 0, '0);
      tick();
    end
    set_wr_s(0, 1'b1, 110, W'(32'hCAFE));
    set_rd_s(0, 110); set_rd_s(1, 99); set_rd_s(2, 0);
    expn(3, 0, '0); expn(3, 1, '0); expn(3, 2, '0); expn(4, 0, '0); tick();
    set_wr_s(0, 1'b1, 99, W'(32'h77));
    expn(3, 0, '0); expn(3, 1, W'(32'h77)); tick();
    wr_en_s = '0;
    expn(3, 0, '0); expn(3, 1, W'(32'h77)); expn(5, 0, '0); tick();

    repeat (3) tick();
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
